// File: rtl/audio_frame_bit_counter.sv
// audio_frame_bit_counter
// Bit-slot sequencer for serial audio links (I2S, left- and right-justified).
// It follows one channel word inside each LRCK half-frame and drives the
// shift/sample strobes, an MSB-first bit index and a channel tag for the
// serializer and deserializer.
//
// Parameters:
//   DATA_WIDTH      bits per channel word (2..32)
//   FIRST_BIT_DELAY BCLK falling edges between the LRCK edge and the MSB (0..31)
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   enable                1 = accept LRCK edges, 0 = force idle
//   bit_clk_rising_edge   one-clk strobe, BCLK rising edge
//   bit_clk_falling_edge  one-clk strobe, BCLK falling edge
//   lr_clk_rising_edge    one-clk strobe, LRCK rising edge (right channel)
//   lr_clk_falling_edge   one-clk strobe, LRCK falling edge (left channel)
//   counting              high while a word's data bits are in progress
//   bit_index             current data bit, DATA_WIDTH-1 = MSB
//   channel               0 = left, 1 = right, tag of the current/last word
//   tx_shift              pulse: present bit bit_index on the serial output
//   rx_sample             pulse: sample the serial input into bit bit_index
//   word_done             pulse: word complete, channel valid
//   frame_error           pulse: LRCK edge arrived before the word finished
//
// Every output is registered; each pulse lands exactly one clk after the
// strobe that caused it and is one clk wide.
module audio_frame_bit_counter #(
  parameter int DATA_WIDTH      = 16,
  parameter int FIRST_BIT_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       bit_clk_rising_edge,
  input  logic       bit_clk_falling_edge,
  input  logic       lr_clk_rising_edge,
  input  logic       lr_clk_falling_edge,
  output logic       counting,
  output logic [4:0] bit_index,
  output logic       channel,
  output logic       tx_shift,
  output logic       rx_sample,
  output logic       word_done,
  output logic       frame_error
);

  localparam logic [4:0] MSB_INDEX   = 5'(DATA_WIDTH - 1);
  localparam logic [4:0] DELAY_START = 5'(FIRST_BIT_DELAY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] delay_cnt;
  logic       lr_edge;

  assign lr_edge = enable & (lr_clk_rising_edge | lr_clk_falling_edge);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      delay_cnt   <= 5'd0;
      counting    <= 1'b0;
      bit_index   <= 5'd0;
      channel     <= 1'b0;
      tx_shift    <= 1'b0;
      rx_sample   <= 1'b0;
      word_done   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      // Pulses default low so each one lasts a single clk.
      tx_shift    <= 1'b0;
      rx_sample   <= 1'b0;
      word_done   <= 1'b0;
      frame_error <= 1'b0;

      if (!enable) begin
        // Abandon any word silently; channel and bit_index hold.
        state    <= IDLE;
        counting <= 1'b0;
      end else if (lr_edge) begin
        // An LRCK edge always restarts the word and swallows any bit-clock
        // strobe of the same cycle. Rising wins if both strobes are set.
        channel     <= lr_clk_rising_edge;
        frame_error <= (state != IDLE);
        if (FIRST_BIT_DELAY == 0) begin
          state     <= ACTIVE;
          bit_index <= MSB_INDEX;
          counting  <= 1'b1;
          tx_shift  <= 1'b1;
        end else begin
          state     <= DELAY;
          delay_cnt <= DELAY_START;
          counting  <= 1'b0;
        end
      end else begin
        case (state)
          DELAY: begin
            if (bit_clk_falling_edge) begin
              if (delay_cnt > 5'd1) begin
                delay_cnt <= delay_cnt - 5'd1;
              end else begin
                state     <= ACTIVE;
                bit_index <= MSB_INDEX;
                counting  <= 1'b1;
                tx_shift  <= 1'b1;
              end
            end
          end
          ACTIVE: begin
            if (bit_clk_rising_edge) begin
              rx_sample <= 1'b1;
            end
            if (bit_clk_falling_edge) begin
              if (bit_index != 5'd0) begin
                bit_index <= bit_index - 5'd1;
                tx_shift  <= 1'b1;
              end else begin
                // Last bit was sampled on the preceding rising edge.
                state     <= IDLE;
                counting  <= 1'b0;
                word_done <= 1'b1;
              end
            end
          end
          default: begin
            // IDLE ignores bit-clock strobes.
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_frame_bit_counter.sv
// tb_audio_frame_bit_counter
// Directed bench for audio_frame_bit_counter. Three instances share one
// stimulus stream: [0] I2S 16/1, [1] left-justified 24/0, [2] right-justified
// 16/16 (32-bit slot). Each scenario checks the instance it targets.
module tb_audio_frame_bit_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic bclk_rise = 1'b0;
  logic bclk_fall = 1'b0;
  logic lr_rise = 1'b0;
  logic lr_fall = 1'b0;

  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  logic [2:0] cnt_o;
  logic [2:0] ch_o;
  logic [2:0] tx_o;
  logic [2:0] rx_o;
  logic [2:0] wd_o;
  logic [2:0] fe_o;
  logic [4:0] bi_o [3];

  audio_frame_bit_counter #(.DATA_WIDTH(16), .FIRST_BIT_DELAY(1)) u_i2s (
    .clk(clk), .reset(reset), .enable(enable),
    .bit_clk_rising_edge(bclk_rise), .bit_clk_falling_edge(bclk_fall),
    .lr_clk_rising_edge(lr_rise), .lr_clk_falling_edge(lr_fall),
    .counting(cnt_o[0]), .bit_index(bi_o[0]), .channel(ch_o[0]),
    .tx_shift(tx_o[0]), .rx_sample(rx_o[0]), .word_done(wd_o[0]),
    .frame_error(fe_o[0])
  );

  audio_frame_bit_counter #(.DATA_WIDTH(24), .FIRST_BIT_DELAY(0)) u_lj (
    .clk(clk), .reset(reset), .enable(enable),
    .bit_clk_rising_edge(bclk_rise), .bit_clk_falling_edge(bclk_fall),
    .lr_clk_rising_edge(lr_rise), .lr_clk_falling_edge(lr_fall),
    .counting(cnt_o[1]), .bit_index(bi_o[1]), .channel(ch_o[1]),
    .tx_shift(tx_o[1]), .rx_sample(rx_o[1]), .word_done(wd_o[1]),
    .frame_error(fe_o[1])
  );

  audio_frame_bit_counter #(.DATA_WIDTH(16), .FIRST_BIT_DELAY(16)) u_rj (
    .clk(clk), .reset(reset), .enable(enable),
    .bit_clk_rising_edge(bclk_rise), .bit_clk_falling_edge(bclk_fall),
    .lr_clk_rising_edge(lr_rise), .lr_clk_falling_edge(lr_fall),
    .counting(cnt_o[2]), .bit_index(bi_o[2]), .channel(ch_o[2]),
    .tx_shift(tx_o[2]), .rx_sample(rx_o[2]), .word_done(wd_o[2]),
    .frame_error(fe_o[2])
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int tx_n [3] = '{0, 0, 0};
  int rx_n [3] = '{0, 0, 0};
  int wd_n [3] = '{0, 0, 0};
  int fe_n [3] = '{0, 0, 0};
  int sb_sel   = 3;  // instance whose bit indices are scoreboarded, 3 = none
  logic [4:0] exp_q [$];     // expected bit_index at each tx_shift
  logic [4:0] exp_rx_q [$];  // expected bit_index at each rx_sample

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Samples outputs once per clk, 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tx_n[i] += int'(tx_o[i]);
      rx_n[i] += int'(rx_o[i]);
      wd_n[i] += int'(wd_o[i]);
      fe_n[i] += int'(fe_o[i]);
    end
    if (sb_sel < 3) begin
      if (tx_o[sb_sel]) begin
        if (exp_q.size() == 0) check("tx_extra", 1, 0);
        else check("tx_bit_index", 32'(bi_o[sb_sel]), 32'(exp_q.pop_front()));
      end
      if (rx_o[sb_sel]) begin
        if (exp_rx_q.size() == 0) check("rx_extra", 1, 0);
        else check("rx_bit_index", 32'(bi_o[sb_sel]), 32'(exp_rx_q.pop_front()));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb_sel = 3;
    exp_q.delete();
    exp_rx_q.delete();
  endtask

  task automatic strobe_lr(input logic rising);
    if (rising) lr_rise = 1'b1; else lr_fall = 1'b1;
    tick();
    lr_rise = 1'b0;
    lr_fall = 1'b0;
  endtask

  task automatic bclk_period();
    bclk_rise = 1'b1; tick(); bclk_rise = 1'b0; tick();
    bclk_fall = 1'b1; tick(); bclk_fall = 1'b0; tick();
  endtask

  task automatic bclk_periods(input int n);
    for (int i = 0; i < n; i++) bclk_period();
  endtask

  task automatic load_sb(input int sel, input int width);
    sb_sel = sel;
    for (int b = width - 1; b >= 0; b--) begin
      exp_q.push_back(5'(b));
      exp_rx_q.push_back(5'(b));
    end
  endtask

  int base_tx;
  int base_rx;
  int base_wd;
  int base_fe;

  initial begin
    // ---- reset state ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("reset_outputs",
            {cnt_o[i], bi_o[i], ch_o[i], tx_o[i], rx_o[i], wd_o[i], fe_o[i]}, 0);
    end

    // ---- I2S 16/1, left channel ----
    do_reset();
    load_sb(0, 16);
    base_tx = tx_n[0]; base_rx = rx_n[0]; base_wd = wd_n[0]; base_fe = fe_n[0];
    strobe_lr(1'b0);
    check("i2s_delay_counting", cnt_o[0], 0);
    bclk_period();
    check("i2s_counting_after_fall1", cnt_o[0], 1);
    check("i2s_msb_index", bi_o[0], 15);
    bclk_periods(15);
    check("i2s_no_done_at_16", wd_n[0] - base_wd, 0);
    check("i2s_counting_at_16", cnt_o[0], 1);
    bclk_period();
    check("i2s_done_at_17", wd_n[0] - base_wd, 1);
    check("i2s_channel", ch_o[0], 0);
    check("i2s_counting_end", cnt_o[0], 0);
    bclk_period();
    check("i2s_tx_count", tx_n[0] - base_tx, 16);
    check("i2s_rx_count", rx_n[0] - base_rx, 16);
    check("i2s_index_holds_0", bi_o[0], 0);
    check("i2s_no_error", fe_n[0] - base_fe, 0);
    check("i2s_sb_drained", exp_q.size() + exp_rx_q.size(), 0);

    // ---- left-justified 24/0, right channel ----
    do_reset();
    load_sb(1, 24);
    base_tx = tx_n[1]; base_rx = rx_n[1]; base_wd = wd_n[1];
    strobe_lr(1'b1);
    check("lj_tx_after_lr", tx_o[1], 1);
    check("lj_msb_index", bi_o[1], 23);
    check("lj_channel", ch_o[1], 1);
    bclk_periods(23);
    check("lj_no_done_at_23", wd_n[1] - base_wd, 0);
    bclk_period();
    check("lj_done_at_24", wd_n[1] - base_wd, 1);
    check("lj_tx_count", tx_n[1] - base_tx, 24);
    check("lj_rx_count", rx_n[1] - base_rx, 24);
    check("lj_sb_drained", exp_q.size() + exp_rx_q.size(), 0);

    // ---- right-justified 16/16 in a 32-bit slot ----
    do_reset();
    load_sb(2, 16);
    base_tx = tx_n[2]; base_rx = rx_n[2]; base_wd = wd_n[2];
    strobe_lr(1'b0);
    bclk_periods(15);
    check("rj_no_tx_at_15", tx_n[2] - base_tx, 0);
    bclk_period();
    check("rj_first_tx_at_16", tx_n[2] - base_tx, 1);
    check("rj_msb_index", bi_o[2], 15);
    bclk_periods(15);
    check("rj_no_done_at_31", wd_n[2] - base_wd, 0);
    bclk_period();
    check("rj_done_at_32", wd_n[2] - base_wd, 1);
    check("rj_rx_count", rx_n[2] - base_rx, 16);

    // ---- short frame at bit_index 5 ----
    do_reset();
    strobe_lr(1'b0);
    bclk_periods(11);
    check("short_index_5", bi_o[0], 5);
    base_wd = wd_n[0];
    strobe_lr(1'b1);
    check("short_frame_error", fe_o[0], 1);
    check("short_lj_frame_error", fe_o[1], 1);
    check("short_lj_restart_index", bi_o[1], 23);
    check("short_channel_toggled", ch_o[0], 1);
    check("short_redelay", cnt_o[0], 0);
    tick();
    check("short_error_one_clk", fe_o[0], 0);
    bclk_period();
    check("short_restart_index", bi_o[0], 15);
    check("short_restart_counting", cnt_o[0], 1);
    check("short_no_done", wd_n[0] - base_wd, 0);

    // ---- LRCK and BCLK falling together at bit_index 3 ----
    do_reset();
    strobe_lr(1'b0);
    bclk_periods(13);
    check("coll_index_3", bi_o[0], 3);
    base_tx = tx_n[0];
    lr_rise = 1'b1; bclk_fall = 1'b1;
    tick();
    lr_rise = 1'b0; bclk_fall = 1'b0;
    check("coll_index_held", bi_o[0], 3);
    check("coll_no_tx", tx_n[0] - base_tx, 0);
    check("coll_frame_error", fe_o[0], 1);
    check("coll_channel", ch_o[0], 1);

    // ---- reset mid-word at bit_index 7 ----
    do_reset();
    strobe_lr(1'b0);
    bclk_periods(9);
    check("rst_index_7", bi_o[0], 7);
    reset = 1'b1;
    bclk_fall = 1'b1;
    tick();
    bclk_fall = 1'b0;
    check("rst_outputs_zero",
          {cnt_o[0], bi_o[0], ch_o[0], tx_o[0], rx_o[0], wd_o[0], fe_o[0]}, 0);
    reset = 1'b0;
    tick();

    // ---- enable dropped mid-word ----
    strobe_lr(1'b1);
    bclk_periods(5);
    check("en_counting_before", cnt_o[0], 1);
    base_tx = tx_n[0]; base_wd = wd_n[0]; base_fe = fe_n[0];
    enable = 1'b0;
    tick();
    check("en_counting_dropped", cnt_o[0], 0);
    bclk_periods(3);
    strobe_lr(1'b0);
    bclk_periods(20);
    check("en_no_done", wd_n[0] - base_wd, 0);
    check("en_no_error", fe_n[0] - base_fe, 0);
    check("en_no_tx", tx_n[0] - base_tx, 0);
    check("en_lr_ignored_counting", cnt_o[1], 0);
    check("en_channel_held", ch_o[0], 1);
    enable = 1'b1;
    strobe_lr(1'b0);
    check("en_resume_lj_tx", tx_o[1], 1);
    check("en_resume_channel", ch_o[1], 0);
    check("en_resume_no_error", fe_o[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
